pipeline_decode: RTL
====================

Name: pipeline_decode

Overview:
DECODE stage of the 5-stage MIPS pipeline. It sits between FETCH and ALU/EX. It latches the PC/instruction/exception bundle from FETCH and reads the register file, with write-back bypass. It detects load-use and mul/div-result interlocks, drives `stall_request` and `early_branch_cmd` back to FETCH, and issues a registered, decoded bundle to EX.

Parameters:
- MULDIV_STALL, 2: stall cycles (1..3) requested when MFHI/MFLO is in D while MULT/MULTU/DIV/DIVU is in EX.
- LOAD_STALL, 1: stall cycles (1..3) requested on a load-use hazard.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- flush  input  1  late branch taken in EX this cycle; squash D contents
- pc_in  input  32  PC from FETCH
- inst_in  input  32  instruction from FETCH; 0 = bubble
- br_late_done_in  input  1  late-branch-done flag from FETCH, aligned with inst_in
- fetch_exception  input  3  FETCH exception code, aligned with inst_in
- early_branch_cmd  output  4  early branch command to FETCH
- stall_request  output  2  stall cycles requested from FETCH; 0 = none
- rf_raddr1  output  5  register-file read address (rs)
- rf_raddr2  output  5  register-file read address (rt)
- rf_rdata1  input  32  async read data, port 1
- rf_rdata2  input  32  async read data, port 2
- wb_we  input  1  write-back enable
- wb_addr  input  5  write-back register
- wb_data  input  32  write-back data
- ex_valid  output  1  EX bundle valid
- ex_pc  output  32  issued PC
- ex_inst  output  32  issued instruction
- ex_rs_val  output  32  rs operand
- ex_rt_val  output  32  rt operand
- ex_dest  output  5  destination register; 0 = none
- ex_is_load  output  1  issued instruction is a load
- ex_is_muldiv  output  1  issued instruction is MULT/MULTU/DIV/DIVU
- ex_exception  output  3  exception code
- ex_br_late_done  output  1  forwarded late-branch-done flag

Behaviour:
- D register: holds pc, inst, exception, br_late_done and a `d_fresh` flag.
  - Captures from FETCH every cycle unless hold is active.
  - While hold is active, inst_in is ignored; FETCH outputs nop and replays.
- Hold sources:
  - Hazard hit this cycle.
  - Internal counter `hold_cnt` nonzero.
- stall_request:
  - Depends on registered state only; no combinational path from inst_in.
  - Load-use: EX holds a load with ex_dest!=0, and D inst reads that register (rs or rt as a source) -> LOAD_STALL.
  - Mul/div result: D inst is MFHI/MFLO and ex_is_muldiv -> MULDIV_STALL.
  - Both hazards together -> the maximum of the two values.
  - stall_request is a 1-cycle pulse; `hold_cnt` <= value-1 and then decrements to 0.
  - No new request while hold_cnt!=0.
- Issue:
  - Hold or bubble cycle -> ex_valid=0, ex_inst=0, ex_dest=0, ex_is_load=0, ex_is_muldiv=0.
  - Otherwise all ex_* outputs register the decoded D contents at the next posedge.
- Destination register:
  - R-type -> rd, except JR/MULT/MULTU/DIV/DIVU -> 0.
  - I-type ALU and loads (LB/LH/LW/LBU/LHU) -> rt.
  - JAL -> 31; JALR -> rd.
  - Stores, branches, J -> 0.
- Operands:
  - rf_raddr1 = D inst[25:21]; rf_raddr2 = D inst[20:16].
  - Bypass: if wb_we and wb_addr!=0 and wb_addr matches the read address, use wb_data instead of rf_rdata.
  - Register 0 always reads 0.
- early_branch_cmd: nonzero only when d_fresh, ex_exception==0 and no flush.
  - 1 = J
  - 2 = JAL
  - 3 = conditional branch, backward offset (inst[15]=1)
  - 4 = conditional branch, forward offset
  - 5 = JR/JALR
  - Otherwise 0.
- d_fresh: set on capture of a nonzero instruction; cleared after one cycle, so the command pulses once per instruction.
- Exceptions:
  - fetch_exception!=0 -> passed through; dest forced to 0.
  - Otherwise an undefined opcode -> ex_exception=3'd4 with dest 0.
- Flush (priority over hold):
  - Clears the D register to bubble and clears hold_cnt.
  - Next EX bundle is invalid.
  - stall_request=0 and early_branch_cmd=0 in the flush cycle.
- Reset (also mid-stall): every output is 0; the D register holds a bubble; hold_cnt=0.
- Latency: 1 cycle from D capture to EX issue when no hazard.

Test Plan:
- Back-to-back ADDU $3,$1,$2 then ORI $4,$3,5 with no loads -> no stall; each issued 1 cycle after capture with ex_dest 3 and then 4.
- LW $5,0($1) then ADDU $6,$5,$2 -> stall_request=1 for exactly one cycle, one bubble (ex_valid=0), then ADDU issues with ex_rs_val = value written back.
- MULT $1,$2 then MFHI $7 with MULDIV_STALL=2 -> stall_request=2 pulse, two bubbles, then MFHI issues with ex_dest=7.
- J 0x100 captured -> early_branch_cmd=1 for one cycle only. BEQ with offset 0xFFFC -> cmd 3; offset 0x0004 -> cmd 4.
- wb_we=1, wb_addr=9, wb_data=0xDEADBEEF while D reads $9, rf_rdata stale -> ex_rs_val=0xDEADBEEF. Read of $0 -> 0.
- flush asserted during a 2-cycle hold -> bubble issued, hold_cnt=0, stall_request=0. rst mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pipeline_decode.sv
`default_nettype none
// ============================================================================
// pipeline_decode : MIPS DECODE stage (operand read/bypass, interlocks,
//                   early branch command, registered issue bundle to EX)
// Rev 1.0
// ============================================================================
module pipeline_decode #(
  parameter int MULDIV_STALL = 2,
  parameter int LOAD_STALL   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        br_late_done_in,
  input  logic [2:0]  fetch_exception,
  output logic [3:0]  early_branch_cmd,
  output logic [1:0]  stall_request,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [4:0]  ex_dest,
  output logic        ex_is_load,
  output logic        ex_is_muldiv,
  output logic [2:0]  ex_exception,
  output logic        ex_br_late_done
);

  localparam logic [5:0] c_OP_SPECIAL = 6'h00, c_OP_REGIMM = 6'h01, c_OP_J    = 6'h02,
                         c_OP_JAL     = 6'h03, c_OP_BEQ    = 6'h04, c_OP_BNE  = 6'h05,
                         c_OP_BLEZ    = 6'h06, c_OP_BGTZ   = 6'h07, c_OP_ADDI = 6'h08,
                         c_OP_ADDIU   = 6'h09, c_OP_SLTI   = 6'h0A, c_OP_SLTIU = 6'h0B,
                         c_OP_ANDI    = 6'h0C, c_OP_ORI    = 6'h0D, c_OP_XORI = 6'h0E,
                         c_OP_LUI     = 6'h0F, c_OP_LB     = 6'h20, c_OP_LH   = 6'h21,
                         c_OP_LW      = 6'h23, c_OP_LBU    = 6'h24, c_OP_LHU  = 6'h25,
                         c_OP_SB      = 6'h28, c_OP_SH     = 6'h29, c_OP_SW   = 6'h2B;
  localparam logic [5:0] c_FN_JR   = 6'h08, c_FN_JALR = 6'h09, c_FN_MFHI  = 6'h10,
                         c_FN_MFLO = 6'h12, c_FN_MULT = 6'h18, c_FN_MULTU = 6'h19,
                         c_FN_DIV  = 6'h1A, c_FN_DIVU = 6'h1B;
  localparam logic [1:0] c_LOAD_STALL   = 2'(LOAD_STALL);
  localparam logic [1:0] c_MULDIV_STALL = 2'(MULDIV_STALL);
  localparam logic [1:0] c_BOTH_STALL   = (c_MULDIV_STALL > c_LOAD_STALL) ? c_MULDIV_STALL
                                                                          : c_LOAD_STALL;

  logic [31:0] r_d_pc, r_d_inst;
  logic [2:0]  r_d_exc;
  logic        r_d_bld, r_d_fresh;
  logic [1:0]  r_hold_cnt;

  logic        r_ex_valid, r_ex_is_load, r_ex_is_muldiv, r_ex_bld;
  logic [31:0] r_ex_pc, r_ex_inst, r_ex_rs_val, r_ex_rt_val;
  logic [4:0]  r_ex_dest;
  logic [2:0]  r_ex_exc;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [4:0]  w_dest, w_dest_final;
  logic        w_is_load, w_is_muldiv, w_is_mfhilo, w_undef, w_uses_rs, w_uses_rt;
  logic [3:0]  w_br_cmd, w_cond_cmd;
  logic [2:0]  w_exc;
  logic        w_d_valid, w_load_hit, w_muldiv_hit, w_hazard, w_hold;
  logic [1:0]  w_stall_val;
  logic [31:0] w_rs_val, w_rt_val;

  assign w_op       = r_d_inst[31:26];
  assign w_rs       = r_d_inst[25:21];
  assign w_rt       = r_d_inst[20:16];
  assign w_rd       = r_d_inst[15:11];
  assign w_funct    = r_d_inst[5:0];
  assign w_cond_cmd = r_d_inst[15] ? 4'd3 : 4'd4;

  always_comb begin
    w_dest      = 5'd0;
    w_is_load   = 1'b0;
    w_is_muldiv = 1'b0;
    w_is_mfhilo = 1'b0;
    w_undef     = 1'b0;
    w_uses_rs   = 1'b0;
    w_uses_rt   = 1'b0;
    w_br_cmd    = 4'd0;
    case (w_op)
      c_OP_SPECIAL: begin
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b1;
        w_dest    = w_rd;
        case (w_funct)
          c_FN_JR: begin
            w_dest   = 5'd0;
            w_br_cmd = 4'd5;
          end
          c_FN_JALR: w_br_cmd = 4'd5;
          c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU: begin
            w_dest      = 5'd0;
            w_is_muldiv = 1'b1;
          end
          c_FN_MFHI, c_FN_MFLO: w_is_mfhilo = 1'b1;
          default: ;
        endcase
      end
      c_OP_REGIMM, c_OP_BLEZ, c_OP_BGTZ: begin
        w_uses_rs = 1'b1;
        w_br_cmd  = w_cond_cmd;
      end
      c_OP_BEQ, c_OP_BNE: begin
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b1;
        w_br_cmd  = w_cond_cmd;
      end
      c_OP_J:   w_br_cmd = 4'd1;
      c_OP_JAL: begin
        w_br_cmd = 4'd2;
        w_dest   = 5'd31;
      end
      c_OP_ADDI, c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU,
      c_OP_ANDI, c_OP_ORI, c_OP_XORI, c_OP_LUI: begin
        w_uses_rs = 1'b1;
        w_dest    = w_rt;
      end
      c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU, c_OP_LHU: begin
        w_uses_rs = 1'b1;
        w_dest    = w_rt;
        w_is_load = 1'b1;
      end
      c_OP_SB, c_OP_SH, c_OP_SW: begin
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b1;
      end
      default: w_undef = 1'b1;
    endcase
  end

  // A FETCH exception wins over a locally detected undefined opcode.
  assign w_exc        = (r_d_exc != 3'd0) ? r_d_exc : (w_undef ? 3'd4 : 3'd0);
  assign w_dest_final = (w_exc != 3'd0) ? 5'd0 : w_dest;

  // Interlocks look only at D and EX registers so FETCH sees no path from inst_in.
  assign w_d_valid    = (r_d_inst != 32'd0);
  assign w_load_hit   = r_ex_is_load && (r_ex_dest != 5'd0) &&
                        ((w_uses_rs && (w_rs == r_ex_dest)) || (w_uses_rt && (w_rt == r_ex_dest)));
  assign w_muldiv_hit = w_is_mfhilo && r_ex_is_muldiv;
  assign w_hazard     = w_d_valid && !flush && (r_hold_cnt == 2'd0) && (w_load_hit || w_muldiv_hit);
  assign w_stall_val  = (w_load_hit && w_muldiv_hit) ? c_BOTH_STALL :
                        (w_load_hit ? c_LOAD_STALL : c_MULDIV_STALL);
  assign w_hold       = w_hazard || (r_hold_cnt != 2'd0);

  assign stall_request    = w_hazard ? w_stall_val : 2'd0;
  assign early_branch_cmd = (r_d_fresh && (r_ex_exc == 3'd0) && !flush) ? w_br_cmd : 4'd0;

  assign rf_raddr1 = w_rs;
  assign rf_raddr2 = w_rt;
  assign w_rs_val  = (w_rs == 5'd0) ? 32'd0 : ((wb_we && (wb_addr == w_rs)) ? wb_data : rf_rdata1);
  assign w_rt_val  = (w_rt == 5'd0) ? 32'd0 : ((wb_we && (wb_addr == w_rt)) ? wb_data : rf_rdata2);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_d_pc     <= 32'd0;
      r_d_inst   <= 32'd0;
      r_d_exc    <= 3'd0;
      r_d_bld    <= 1'b0;
      r_d_fresh  <= 1'b0;
      r_hold_cnt <= 2'd0;
    end else if (w_hold) begin
      r_d_fresh  <= 1'b0;
      r_hold_cnt <= w_hazard ? (w_stall_val - 2'd1) : (r_hold_cnt - 2'd1);
    end else begin
      r_d_pc     <= pc_in;
      r_d_inst   <= inst_in;
      r_d_exc    <= fetch_exception;
      r_d_bld    <= br_late_done_in;
      r_d_fresh  <= (inst_in != 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush || w_hold) begin
      r_ex_valid     <= 1'b0;
      r_ex_pc        <= 32'd0;
      r_ex_inst      <= 32'd0;
      r_ex_rs_val    <= 32'd0;
      r_ex_rt_val    <= 32'd0;
      r_ex_dest      <= 5'd0;
      r_ex_is_load   <= 1'b0;
      r_ex_is_muldiv <= 1'b0;
      r_ex_exc       <= 3'd0;
      r_ex_bld       <= 1'b0;
    end else begin
      r_ex_valid     <= w_d_valid;
      r_ex_pc        <= r_d_pc;
      r_ex_inst      <= r_d_inst;
      r_ex_rs_val    <= w_rs_val;
      r_ex_rt_val    <= w_rt_val;
      r_ex_dest      <= w_dest_final;
      r_ex_is_load   <= w_is_load;
      r_ex_is_muldiv <= w_is_muldiv;
      r_ex_exc       <= w_exc;
      r_ex_bld       <= r_d_bld;
    end
  end

  assign ex_valid        = r_ex_valid;
  assign ex_pc           = r_ex_pc;
  assign ex_inst         = r_ex_inst;
  assign ex_rs_val       = r_ex_rs_val;
  assign ex_rt_val       = r_ex_rt_val;
  assign ex_dest         = r_ex_dest;
  assign ex_is_load      = r_ex_is_load;
  assign ex_is_muldiv    = r_ex_is_muldiv;
  assign ex_exception    = r_ex_exc;
  assign ex_br_late_done = r_ex_bld;

endmodule
`default_nettype wire
